// File: rtl/fifo_8x32.sv
// Eight-entry first-word-fall-through FIFO with valid/ready on both sides.
// Head entry is presented combinationally from an 8-to-1 select on the read pointer.
module fifo_8x32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // wr_ready depends only on occupancy, never on rd_ready.

    logic [2:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] mem_q [8];
    logic [WIDTH-1:0] mem_d [8];
    logic [7:0]       slot_en;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_data;

    assign full     = (count_q == 4'd8);
    assign empty    = (count_q == 4'd0);
    assign wr_ready = ~full;
    assign rd_valid = ~empty;
    assign count    = count_q;

    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    always_comb begin
        slot_en = 8'd0;
        if (push && !flush) begin
            slot_en[wr_ptr_q] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mem_d[i] = mem_q[i];
            if (slot_en[i]) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 3'd0;
            rd_ptr_d = 3'd0;
            count_d  = 4'd0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 3'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        head_data = '0;
        case (rd_ptr_q)
            3'd0: head_data = mem_q[0];
            3'd1: head_data = mem_q[1];
            3'd2: head_data = mem_q[2];
            3'd3: head_data = mem_q[3];
            3'd4: head_data = mem_q[4];
            3'd5: head_data = mem_q[5];
            3'd6: head_data = mem_q[6];
            3'd7: head_data = mem_q[7];
            default: head_data = '0;
        endcase
    end

    // Forced to zero when empty so stale storage never leaks onto the bus.
    assign rd_data = empty ? '0 : head_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
